store_unit: RTL and testbench

//  Store-side memory path for mips-lite: the narrowing counterpart of load extension.
//  - Takes a 32-bit rt value, effective address and size (sb/sh/sw).
//  - Truncates the value to the store width, steers it onto little-endian byte lanes and

---
 rtl/mem_pkg.sv | 32 +++
 rtl/store_lane_align.sv | 53 +++++
 rtl/store_unit.sv | 159 +++++++++++++++
 tb/tb_store_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the mips-lite store path.
//   - SZ_* : encodings of the 2-bit store size field (sb/sh/sw/reserved)
//   - st_state_t : store_unit FSM states
//   - size_mask() : low-aligned byte-enable pattern for a store size
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ1 = 2'd1,
        REQ2 = 2'd2,
        DONE = 2'd3
    } st_state_t;

    // Byte-enable pattern for a store that starts at lane 0; reserved size -> none.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            SZ_WORD: size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// -----------------------------------------------------------------------------
// store_lane_align
// Combinational lane steering for stores. Truncates the register value to the
// store width and shifts it onto little-endian byte lanes. The result is
// computed over a 64-bit (two word) window so that a misaligned store can be
// issued as two aligned writes: *_lo is the word at addr & ~3, *_hi the next.
// Ports:
//   size_i       store size (mem_pkg SZ_*)
//   off_i        byte offset addr[1:0]
//   data_i       untruncated rt value
//   be_lo_o      byte enables for the lower word
//   be_hi_o      byte enables for the upper word (nonzero only if store crosses)
//   wdata_lo_o   lane-steered data for the lower word, unused lanes 0
//   wdata_hi_o   lane-steered data for the upper word, unused lanes 0
//   misaligned_o half at odd offset, or word at nonzero offset
// -----------------------------------------------------------------------------
module store_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [3:0]  be_lo_o,
    output logic [3:0]  be_hi_o,
    output logic [31:0] wdata_lo_o,
    output logic [31:0] wdata_hi_o,
    output logic        misaligned_o
);

    logic [31:0] data_trunc;
    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;

    always_comb begin
        case (size_i)
            SZ_BYTE: data_trunc = {24'b0, data_i[7:0]};
            SZ_HALF: data_trunc = {16'b0, data_i[15:0]};
            default: data_trunc = data_i;
        endcase

        be_wide    = {4'b0000, size_mask(size_i)} << off_i;
        wdata_wide = {32'b0, data_trunc} << {off_i, 3'b000};

        be_lo_o    = be_wide[3:0];
        be_hi_o    = be_wide[7:4];
        wdata_lo_o = wdata_wide[31:0];
        wdata_hi_o = wdata_wide[63:32];

        misaligned_o = ((size_i == SZ_HALF) && off_i[0]) ||
                       ((size_i == SZ_WORD) && (off_i != 2'b00));
    end

endmodule

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
// Store-side memory path for mips-lite. Accepts a store from the pipeline,
// steers the data onto byte lanes, issues the write over a req/ack handshake
// and returns a one-cycle done pulse (with error flag) to the controller.
// Build option: define MISALIGNED_SPLIT_EN to split misaligned half/word
// stores into two aligned writes; otherwise they complete with st_err and no
// memory traffic.
// Parameters:
//   TIMEOUT_CYCLES  max cycles a request waits for mem_ack (0 = wait forever)
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   st_valid/st_ready   pipeline store handshake
//   st_size/addr/data   store size, byte address, raw rt value
//   st_done/st_err      completion pulse and its error flag
//   mem_req/mem_ack     memory write handshake
//   mem_addr/wdata/be   word address, lane-steered data, byte enables
// -----------------------------------------------------------------------------
module store_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_done,
    output logic        st_err,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be
);

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic [3:0]  be_lo, be_hi;
    logic [31:0] wdata_lo, wdata_hi;
    logic        misaligned;

    store_lane_align u_align (
        .size_i       (st_size),
        .off_i        (st_addr[1:0]),
        .data_i       (st_data),
        .be_lo_o      (be_lo),
        .be_hi_o      (be_hi),
        .wdata_lo_o   (wdata_lo),
        .wdata_hi_o   (wdata_hi),
        .misaligned_o (misaligned)
    );

    st_state_t   state_q;
    logic [31:0] cnt_q;
    logic [31:0] hi_wdata_q;
    logic [3:0]  hi_be_q;
    logic        need_hi_q;
    logic        st_ready_q, st_done_q, st_err_q, mem_req_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_be_q;

    logic reject;
    logic timeout_hit;

    // Reserved size always fails; misalignment fails only when it cannot be split.
    assign reject      = (st_size == SZ_RSVD) || (misaligned && !SPLIT_EN);
    // Counter starts at 0 on request entry, so the last allowed request
    // cycle is TIMEOUT_CYCLES-1.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_wdata_q  <= '0;
            hi_be_q     <= '0;
            need_hi_q   <= 1'b0;
            st_ready_q  <= 1'b1;
            st_done_q   <= 1'b0;
            st_err_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (st_valid) begin
                        st_ready_q <= 1'b0;
                        cnt_q      <= '0;
                        hi_wdata_q <= wdata_hi;
                        hi_be_q    <= be_hi;
                        need_hi_q  <= SPLIT_EN && (be_hi != 4'b0000);
                        if (reject) begin
                            state_q   <= DONE;
                            st_done_q <= 1'b1;
                            st_err_q  <= 1'b1;
                        end else begin
                            state_q     <= REQ1;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {st_addr[31:2], 2'b00};
                            mem_wdata_q <= wdata_lo;
                            mem_be_q    <= be_lo;
                        end
                    end
                end
                REQ1, REQ2: begin
                    if (mem_ack) begin
                        cnt_q <= '0;
                        if ((state_q == REQ1) && need_hi_q) begin
                            // Second half of a split store: next word, upper lanes.
                            state_q     <= REQ2;
                            mem_addr_q  <= mem_addr_q + 32'd4;
                            mem_wdata_q <= hi_wdata_q;
                            mem_be_q    <= hi_be_q;
                        end else begin
                            state_q   <= DONE;
                            mem_req_q <= 1'b0;
                            st_done_q <= 1'b1;
                            st_err_q  <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        // Abandon the write; an already-acked first half stays written.
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        st_done_q <= 1'b1;
                        st_err_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    st_done_q  <= 1'b0;
                    st_err_q   <= 1'b0;
                    st_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign st_ready  = st_ready_q;
    assign st_done   = st_done_q;
    assign st_err    = st_err_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
// Directed testbench for store_unit (TIMEOUT_CYCLES = 4). Inputs are driven
// and outputs sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_store_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_done;
    logic        st_err;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_size   (st_size),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_done   (st_done),
        .st_err    (st_err),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge while the unit is idle; returns at the falling
    // edge of the cycle after the accept.
    task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_size  = sz;
        st_addr  = a;
        st_data  = d;
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    logic [31:0] addr6 [3];
    logic [31:0] data6 [3];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  req_cnt;
        bit  seen;
        int  acc, reqs, dones;

        reset    = 1'b1;
        st_valid = 1'b0;
        st_size  = 2'b00;
        st_addr  = '0;
        st_data  = '0;
        mem_ack  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst st_ready", 64'(st_ready), 64'd1);
        chk("rst st_done",  64'(st_done),  64'd0);
        chk("rst st_err",   64'(st_err),   64'd0);
        chk("rst mem_req",  64'(mem_req),  64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        chk("rst mem_wdata",64'(mem_wdata),64'd0);
        chk("rst mem_be",   64'(mem_be),   64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: sb 0x1003, immediate ack
        issue(SZ_BYTE, 32'h0000_1003, 32'hAABB_CCDD);
        chk("t1 mem_req",  64'(mem_req),   64'd1);
        chk("t1 mem_addr", 64'(mem_addr),  64'h1000);
        chk("t1 mem_be",   64'(mem_be),    64'b1000);
        chk("t1 mem_wdata",64'(mem_wdata), 64'hDD00_0000);
        chk("t1 no early done", 64'(st_done), 64'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t1 st_done",  64'(st_done),  64'd1);
        chk("t1 st_err",   64'(st_err),   64'd0);
        chk("t1 req drop", 64'(mem_req),  64'd0);
        chk("t1 busy",     64'(st_ready), 64'd0);
        @(negedge clk);
        chk("t1 ready back", 64'(st_ready), 64'd1);
        chk("t1 done pulse", 64'(st_done),  64'd0);

        // 2: sh 0x2002, ack in 4th request cycle
        issue(SZ_HALF, 32'h0000_2002, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            chk("t2 mem_req",  64'(mem_req),   64'd1);
            chk("t2 mem_addr", 64'(mem_addr),  64'h2000);
            chk("t2 mem_be",   64'(mem_be),    64'b1100);
            chk("t2 mem_wdata",64'(mem_wdata), 64'h5678_0000);
            chk("t2 no done",  64'(st_done),   64'd0);
            if (i == 3) mem_ack = 1'b1;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("t2 st_done",  64'(st_done), 64'd1);
        chk("t2 st_err",   64'(st_err),  64'd0);
        chk("t2 req drop", 64'(mem_req), 64'd0);
        @(negedge clk);
        chk("t2 single pulse", 64'(st_done),  64'd0);
        chk("t2 ready back",   64'(st_ready), 64'd1);

        // 3: sw 0x3001 (misaligned word)
`ifdef MISALIGNED_SPLIT_EN
        issue(SZ_WORD, 32'h0000_3001, 32'h1122_3344);
        chk("t3 lo req",   64'(mem_req),   64'd1);
        chk("t3 lo addr",  64'(mem_addr),  64'h3000);
        chk("t3 lo be",    64'(mem_be),    64'b1110);
        chk("t3 lo wdata", 64'(mem_wdata), 64'h2233_4400);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("t3 hi req",   64'(mem_req),   64'd1);
        chk("t3 hi addr",  64'(mem_addr),  64'h3004);
        chk("t3 hi be",    64'(mem_be),    64'b0001);
        chk("t3 hi wdata", 64'(mem_wdata), 64'h0000_0011);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t3 st_done",  64'(st_done), 64'd1);
        chk("t3 st_err",   64'(st_err),  64'd0);
        @(negedge clk);
`else
        issue(SZ_WORD, 32'h0000_3001, 32'h1122_3344);
        chk("t3 no mem_req", 64'(mem_req), 64'd0);
        chk("t3 st_done",    64'(st_done), 64'd1);
        chk("t3 st_err",     64'(st_err),  64'd1);
        @(negedge clk);
        chk("t3 no mem_req after", 64'(mem_req), 64'd0);
        chk("t3 single pulse",     64'(st_done), 64'd0);
`endif
        chk("t3 ready back", 64'(st_ready), 64'd1);

        // 4a: reserved size
        issue(SZ_RSVD, 32'h0000_4000, 32'hDEAD_BEEF);
        chk("t4a no mem_req", 64'(mem_req), 64'd0);
        chk("t4a st_done",    64'(st_done), 64'd1);
        chk("t4a st_err",     64'(st_err),  64'd1);
        @(negedge clk);
        chk("t4a ready back", 64'(st_ready), 64'd1);

        // 4b: aligned sw, no ack -> timeout after 4 request cycles
        issue(SZ_WORD, 32'h0000_5000, 32'hCAFE_F00D);
        req_cnt = 0;
        seen    = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (mem_req) req_cnt++;
            if (st_done) begin
                seen = 1'b1;
                chk("t4b st_err", 64'(st_err), 64'd1);
            end else begin
                @(negedge clk);
            end
        end
        chk("t4b done seen",  64'(seen),    64'd1);
        chk("t4b req cycles", 64'(req_cnt), 64'd4);
        @(negedge clk);
        chk("t4b ready back", 64'(st_ready), 64'd1);
        chk("t4b req idle",   64'(mem_req),  64'd0);

        // 5: reset mid-REQ1, then a stray ack
        issue(SZ_WORD, 32'h0000_6000, 32'h1234_5678);
        chk("t5 in req", 64'(mem_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5 async mem_req",  64'(mem_req),   64'd0);
        chk("t5 async st_ready", 64'(st_ready),  64'd1);
        chk("t5 async mem_addr", 64'(mem_addr),  64'd0);
        chk("t5 async wdata",    64'(mem_wdata), 64'd0);
        chk("t5 async be",       64'(mem_be),    64'd0);
        @(negedge clk);
        reset   = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5 ack ignored done", 64'(st_done),  64'd0);
            chk("t5 ack ignored req",  64'(mem_req),  64'd0);
            chk("t5 idle ready",       64'(st_ready), 64'd1);
            @(negedge clk);
        end
        issue(SZ_BYTE, 32'h0000_7001, 32'h0000_0055);
        chk("t5 next addr",  64'(mem_addr),  64'h7000);
        chk("t5 next be",    64'(mem_be),    64'b0010);
        chk("t5 next wdata", 64'(mem_wdata), 64'h0000_5500);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t5 next done", 64'(st_done), 64'd1);
        chk("t5 next err",  64'(st_err),  64'd0);
        @(negedge clk);

        // 6: back-to-back sw with st_valid and mem_ack held high
        addr6[0] = 32'h0000_8000; data6[0] = 32'hA1A2_A3A4;
        addr6[1] = 32'h0000_8004; data6[1] = 32'hB1B2_B3B4;
        addr6[2] = 32'h0000_8008; data6[2] = 32'hC1C2_C3C4;
        acc   = 0;
        reqs  = 0;
        dones = 0;
        mem_ack  = 1'b1;
        st_valid = 1'b1;
        st_size  = SZ_WORD;
        st_addr  = addr6[0];
        st_data  = data6[0];
        for (int c = 0; c < 20; c++) begin
            if (mem_req) begin
                if (reqs < 3) begin
                    chk("t6 req addr",  64'(mem_addr),  64'(addr6[reqs]));
                    chk("t6 req wdata", 64'(mem_wdata), 64'(data6[reqs]));
                end
                reqs++;
            end
            if (st_done) dones++;
            if (st_ready && st_valid) acc++;
            @(negedge clk);
            if (acc < 3) begin
                st_addr = addr6[acc];
                st_data = data6[acc];
            end else begin
                st_valid = 1'b0;
            end
        end
        mem_ack = 1'b0;
        chk("t6 accepts",  64'(acc),   64'd3);
        chk("t6 requests", 64'(reqs),  64'd3);
        chk("t6 dones",    64'(dones), 64'd3);
        chk("t6 idle end", 64'(st_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
